// File: rtl/wc_tile_feeder.sv
// wc_tile_feeder: builds overlapping N-sample tiles (stride S) from a serial
// sample stream for the Winograd core. Rows end on s_last; a partial final
// tile is completed with zeros and flagged with t_last.
module wc_tile_feeder #(
  parameter int W = 10,
  parameter int N = 7,
  parameter int S = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           s_valid,
  output logic           s_ready,
  input  logic [W-1:0]   s_data,
  input  logic           s_last,
  output logic           t_valid,
  input  logic           t_ready,
  output logic [N*W-1:0] t_data,
  output logic           t_last
);

  localparam int CW = $clog2(N + 1);
  localparam int NW = $clog2(S + 1);

  typedef enum logic {FILL, PAD} state_t;

  state_t state, state_next;

  // win[0] is the oldest sample, win[N-1] the newest
  logic [W-1:0]   win       [N];
  logic [W-1:0]   win_shift [N];
  logic [N*W-1:0] tile_word;

  logic [CW-1:0] cnt, cnt_post;
  logic [NW-1:0] nnew, nnew_post;
  logic          first_done;   // a tile has already left during this row

  logic          free;
  logic          do_shift;
  logic          emit_cond;
  logic          emit;
  logic          row_end;
  logic          row_done;
  logic [W-1:0]  shift_in;

  assign free = !t_valid || t_ready;

  // Post-shift view of the window, also packed as the outgoing tile word
  generate
    for (genvar gi = 0; gi < N - 1; gi++) begin : g_shift
      assign win_shift[gi] = win[gi + 1];
    end
    for (genvar gi = 0; gi < N; gi++) begin : g_pack
      assign tile_word[W*gi +: W] = win_shift[gi];
    end
  endgenerate
  assign win_shift[N-1] = shift_in;

  // Saturating post-shift counters
  assign cnt_post  = (cnt  == CW'(N)) ? cnt  : cnt  + 1'b1;
  assign nnew_post = (nnew == NW'(S)) ? nnew : nnew + 1'b1;

  // First tile of a row needs only a full window; later ones need a full stride
  assign emit_cond = (cnt_post == CW'(N)) && (!first_done || nnew_post == NW'(S));
  assign emit      = do_shift && emit_cond;
  assign row_done  = emit && row_end;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FILL;
    else     state <= state_next;
  end

  // Next-state, handshake and shift-source selection
  always_comb begin
    state_next = state;
    s_ready    = 1'b0;
    do_shift   = 1'b0;
    shift_in   = '0;
    row_end    = 1'b0;
    case (state)
      FILL: begin
        s_ready  = free && !rst;
        do_shift = s_valid && s_ready;
        shift_in = s_data;
        row_end  = s_last;
        if (do_shift && s_last && !emit_cond) state_next = PAD;
      end
      PAD: begin
        do_shift = free;
        row_end  = 1'b1;
        if (free && emit_cond) state_next = FILL;
      end
      default: state_next = FILL;
    endcase
  end

  // Window storage: shift on each accepted/padded sample, clear at row end
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_win
      always_ff @(posedge clk or posedge rst) begin
        if (rst)           win[gi] <= '0;
        else if (row_done) win[gi] <= '0;
        else if (do_shift) win[gi] <= win_shift[gi];
      end
    end
  endgenerate

  // Sample counters and first-tile flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      nnew       <= '0;
      first_done <= 1'b0;
    end else if (row_done) begin
      cnt        <= '0;
      nnew       <= '0;
      first_done <= 1'b0;
    end else if (do_shift) begin
      cnt        <= cnt_post;
      nnew       <= emit ? '0 : nnew_post;
      first_done <= first_done || emit;
    end
  end

  // Registered tile output; holds while the core stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t_valid <= 1'b0;
      t_data  <= '0;
      t_last  <= 1'b0;
    end else if (emit) begin
      t_valid <= 1'b1;
      t_data  <= tile_word;
      t_last  <= row_end;
    end else if (t_ready) begin
      t_valid <= 1'b0;
      t_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wc_tile_feeder.sv
// Directed bench for wc_tile_feeder: hand-written expected tiles are queued
// per test and matched against every tile handoff.
module tb_wc_tile_feeder;

  localparam int W = 10;
  localparam int N = 7;
  localparam int S = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           s_valid;
  logic           s_ready;
  logic [W-1:0]   s_data;
  logic           s_last;
  logic           t_valid;
  logic           t_ready;
  logic [N*W-1:0] t_data;
  logic           t_last;

  typedef struct {
    logic [N*W-1:0] data;
    logic           last;
  } tile_t;

  tile_t exp_q[$];
  int    checks    = 0;
  int    errors    = 0;
  int    pad_cnt   = 0;
  int    tile_seen = 0;

  wc_tile_feeder #(.W(W), .N(N), .S(S)) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .t_valid (t_valid),
    .t_ready (t_ready),
    .t_data  (t_data),
    .t_last  (t_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [N*W-1:0] tile7(input int a0, input int a1, input int a2,
                                           input int a3, input int a4, input int a5,
                                           input int a6);
    logic [N*W-1:0] t;
    t = {10'(a6), 10'(a5), 10'(a4), 10'(a3), 10'(a2), 10'(a1), 10'(a0)};
    return t;
  endfunction

  task automatic push(input logic [N*W-1:0] d, input logic l);
    tile_t t;
    t.data = d;
    t.last = l;
    exp_q.push_back(t);
  endtask

  // Handoff monitor plus count of cycles the input is refused while the core is ready
  always @(negedge clk) begin
    if (!rst && t_ready && !s_ready) pad_cnt++;
    if (!rst && t_valid && t_ready) begin
      tile_seen++;
      $display("tile %0d: data=%h last=%b", tile_seen, t_data, t_last);
      if (exp_q.size() == 0) begin
        check("extra_tile", 1, 0);
      end else begin
        tile_t e;
        e = exp_q.pop_front();
        check("tile_data", t_data, e.data);
        check("tile_last", t_last, e.last);
      end
    end
  end

  task automatic send(input int v, input logic l);
    int guard;
    guard    = 0;
    s_valid  = 1'b1;
    s_data   = 10'(v);
    s_last   = l;
    forever begin
      @(negedge clk);
      if (s_ready) begin
        @(posedge clk);
        #1;
        break;
      end
      guard++;
      if (guard > 100) begin
        check("send_timeout", 1, 0);
        break;
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_row(input int first, input int len);
    for (int i = 0; i < len; i++) send(first + i, i == len - 1);
  endtask

  task automatic drain(input int exp_pad);
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 200) begin
      @(posedge clk);
      g++;
    end
    repeat (4) @(posedge clk);
    #1;
    check("tiles_pending", exp_q.size(), 0);
    if (exp_pad >= 0) check("pad_cycles", pad_cnt, exp_pad);
  endtask

  initial begin
    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    t_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_t_valid", t_valid, 0);
    check("rst_t_last",  t_last, 0);
    check("rst_t_data",  t_data, 0);
    check("rst_s_ready", s_ready, 0);
    rst = 1'b0;
    #1;
    check("idle_s_ready", s_ready, 1);

    // Row 1..13: three tiles, no padding
    push(tile7(1, 2, 3, 4, 5, 6, 7), 1'b0);
    push(tile7(4, 5, 6, 7, 8, 9, 10), 1'b0);
    push(tile7(7, 8, 9, 10, 11, 12, 13), 1'b1);
    pad_cnt = 0;
    send_row(1, 13);
    drain(0);

    // Row 1..9: one zero completes the stride
    push(tile7(1, 2, 3, 4, 5, 6, 7), 1'b0);
    push(tile7(4, 5, 6, 7, 8, 9, 0), 1'b1);
    pad_cnt = 0;
    send_row(1, 9);
    drain(1);

    // Short row 1..4: padded to a full tile
    push(tile7(1, 2, 3, 4, 0, 0, 0), 1'b1);
    pad_cnt = 0;
    send_row(1, 4);
    drain(3);

    // Row 1..13 with the core stalled after the first tile
    t_ready = 1'b0;
    push(tile7(1, 2, 3, 4, 5, 6, 7), 1'b0);
    push(tile7(4, 5, 6, 7, 8, 9, 10), 1'b0);
    push(tile7(7, 8, 9, 10, 11, 12, 13), 1'b1);
    fork
      send_row(1, 13);
      begin
        int g;
        g = 0;
        while (!t_valid && g < 50) begin
          @(posedge clk);
          #1;
          g++;
        end
        check("stall_t_valid", t_valid, 1);
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          check("stall_data", t_data, tile7(1, 2, 3, 4, 5, 6, 7));
          check("stall_s_ready", s_ready, 0);
          @(posedge clk);
        end
        #1;
        t_ready = 1'b1;
      end
    join
    drain(-1);

    // Back-to-back rows: no overlap carried across the row boundary
    push(tile7(1, 2, 3, 4, 5, 6, 7), 1'b1);
    push(tile7(20, 21, 22, 23, 24, 25, 26), 1'b1);
    pad_cnt = 0;
    send_row(1, 7);
    send_row(20, 7);
    drain(0);

    // Reset while padding row 1..9: pending tile is dropped
    push(tile7(1, 2, 3, 4, 5, 6, 7), 1'b0);
    send_row(1, 9);
    rst = 1'b1;
    #1;
    check("midrst_t_valid", t_valid, 0);
    check("midrst_s_ready", s_ready, 0);
    check("midrst_t_data",  t_data, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_q", exp_q.size(), 0);
    push(tile7(1, 2, 3, 4, 5, 6, 7), 1'b1);
    pad_cnt = 0;
    send_row(1, 7);
    drain(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wc_tile_feeder.md
Name: wc_tile_feeder

Overview:
- Input-side stage that sits directly upstream of the Winograd F(3,5) core WC.
- Accepts a serial stream of 10-bit samples with a valid/ready handshake.
- Assembles overlapping 7-sample input tiles (stride 3, overlap 4) and presents each as the 70-bit tile word the core consumes on D.
- Handles row boundaries by zero-padding the final partial tile and marking it as last.

Parameters:
- W, 10, sample width in bits
- N, 7, tile length in samples (m+r-1 for F(3,5))
- S, 3, tile stride in samples (m)

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- s_valid  input  1  input sample valid
- s_ready  output  1  feeder can accept a sample this cycle
- s_data  input  W  input sample
- s_last  input  1  qualifies the final sample of a row
- t_valid  output  1  tile word valid
- t_ready  input  1  downstream accepts the tile word
- t_data  output  N*W  tile word; t_data[W*k +: W] = sample k, k=0 is the oldest
- t_last  output  1  marks the final tile of a row

Behaviour:
- Reset (asynchronous, active-high, takes effect immediately):
  - t_valid=0, t_last=0, t_data=0
  - s_ready=0 while rst is high
  - window cleared, cnt=0, nnew=0, state=FILL
- Window:
  - N-entry shift register; each accepted or padded sample shifts in at entry N-1 and the oldest entry drops out.
  - cnt (0..N) counts samples currently in the window.
  - nnew (0..S) counts samples received since the last emitted tile.
- Output register:
  - t_data, t_last and t_valid are registered.
  - "free" = !t_valid || t_ready.
  - A tile is handed off when t_valid && t_ready are both high.
  - t_valid, t_data and t_last hold stable while t_ready=0.
- Emit condition: after the shift, either (cnt==N and this is the first tile of the row) or (cnt==N and nnew==S).
- On emit:
  - Load t_data from the post-shift window and set t_valid=1.
  - nnew clears to 0.
  - Latency: the tile is visible on the cycle after the sample edge that completed it.
- State FILL:
  - s_ready = free.
  - On s_valid && s_ready, shift s_data in.
  - If s_last: the emit/pad decision uses post-shift cnt/nnew.
    - Emit condition met → emit with t_last=1, clear window/cnt/nnew, stay in FILL.
    - Otherwise → go to PAD.
- State PAD:
  - s_ready=0.
  - Each cycle that free=1, shift in a zero.
  - When the emit condition is met, emit with t_last=1, clear window/cnt/nnew, return to FILL.
  - Pad count per row = max(N-cnt, S-nnew) zeros:
    - short row (cnt<N) pads to a full tile;
    - otherwise pads to complete the stride.
- Simultaneous events: an emit in the same cycle as downstream acceptance of the previous tile is legal (free=1); there is no bubble, so throughput is one sample per cycle in steady state.
- Backpressure: with t_valid=1 and t_ready=0, s_ready=0 and no shift occurs; no sample is lost or duplicated.
- s_last on a sample that is not accepted (s_ready=0) has no effect.
- Reset mid-row or mid-PAD: all state is discarded; a pending tile is dropped (t_valid=0).

Test Plan:
- Row of samples 1..13, s_last on 13, t_ready=1 → exactly 3 tiles:
  - [1..7];
  - [4..10];
  - [7..13] with t_last=1;
  - no PAD entry.
- Row 1..9, s_last on 9 → tiles [1..7], then [4,5,6,7,8,9,0] with t_last=1; exactly 1 pad cycle with s_ready=0.
- Short row 1..4, s_last on 4 → single tile [1,2,3,4,0,0,0] with t_last=1; 3 pad cycles.
- Row 1..13 with t_ready held low for 5 cycles after the first tile:
  - t_data stable at [1..7] throughout;
  - s_ready=0 while stalled;
  - after release, the remaining tiles are exact, with none dropped or repeated.
- Back-to-back rows 1..7 (last) then 20..26 (last) → [1..7] t_last=1, then [20..26] t_last=1; the second row has no overlap carried from the first.
- Assert rst during PAD of the row 1..9 case → t_valid=0 immediately; a following row 1..7 yields a single tile [1..7] t_last=1.
